// File: rtl/ghost_pkg.sv
// Shared ghost-mode encodings, game-state constant and the per-level
// schedule/frightened duration tables in ms.
package ghost_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_FRIGHT  = 2'd2
    } mode_t;

    localparam logic [3:0] GS_PLAY = 4'd2;

    // Phase 7 never expires, so its duration is never consulted.
    function automatic logic [20:0] phase_ms(input logic [7:0] level, input logic [2:0] phase);
        logic first_level;
        logic late_level;
        first_level = (level <= 8'd1);
        late_level  = (level >= 8'd5);
        case (phase)
            3'd0, 3'd2: phase_ms = late_level ? 21'd5000 : 21'd7000;
            3'd1, 3'd3: phase_ms = 21'd20000;
            3'd4:       phase_ms = 21'd5000;
            3'd5:       phase_ms = first_level ? 21'd20000 :
                                   (late_level ? 21'd1037000 : 21'd1033000);
            3'd6:       phase_ms = first_level ? 21'd5000 : 21'd17;
            default:    phase_ms = 21'd0;
        endcase
    endfunction

    function automatic logic [12:0] fright_ms(input logic [7:0] level);
        case (level)
            8'd0, 8'd1: fright_ms = 13'd6000;
            8'd2:       fright_ms = 13'd5000;
            8'd3:       fright_ms = 13'd4000;
            8'd4:       fright_ms = 13'd3000;
            8'd5:       fright_ms = 13'd2000;
            default:    fright_ms = 13'd1000;
        endcase
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles and flags the wrap cycle.
module ms_tick_gen #(
    parameter int TICK_CYCLES = 50_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    assign o_tick = i_en && !i_clr && (count == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            count <= '0;
        end else if (i_en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase schedule, frightened timer, reverse/flash requests.
// mode_q: SCATTER | even phase running ; CHASE | odd phase running ; FRIGHT | fright timer nonzero
module ghost_mode_scheduler
    import ghost_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000,
    parameter int FLASH_MS    = 2000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_game_state,
    input  logic [7:0] i_level,
    input  logic       i_ghost_reload,
    input  logic       i_energizer_eaten,
    output logic [1:0] o_mode,
    output logic [2:0] o_phase,
    output logic       o_reverse,
    output logic       o_fright_flash
);

    localparam logic [12:0] FLASH_LIM = 13'(FLASH_MS);

    logic        tick;
    logic [7:0]  level_q;
    logic [20:0] phase_cnt;
    logic [12:0] fright_cnt;
    logic [2:0]  phase_q;
    mode_t       mode_q;
    logic        reverse_q;
    logic        flash_q;
    logic [20:0] phase_dur;
    logic [12:0] fright_dur;

    // Energizer restarts the prescaler so the frightened period is a whole number of ticks.
    ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_game_state == GS_PLAY),
        .i_clr (i_ghost_reload || i_energizer_eaten),
        .o_tick(tick)
    );

    assign phase_dur  = phase_ms(level_q, phase_q);
    assign fright_dur = fright_ms(level_q);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_ghost_reload) begin
            level_q    <= (i_level == 8'd0) ? 8'd1 : i_level;
            phase_cnt  <= '0;
            fright_cnt <= '0;
            phase_q    <= '0;
            mode_q     <= MODE_SCATTER;
            reverse_q  <= 1'b0;
            flash_q    <= 1'b0;
        end else if (i_energizer_eaten) begin
            fright_cnt <= fright_dur;
            mode_q     <= MODE_FRIGHT;
            reverse_q  <= 1'b1;
            flash_q    <= (fright_dur <= FLASH_LIM);
        end else begin
            reverse_q <= 1'b0;
            if (fright_cnt != 13'd0) begin
                if (tick) begin
                    fright_cnt <= fright_cnt - 1'b1;
                    flash_q    <= (fright_cnt != 13'd1) && ((fright_cnt - 1'b1) <= FLASH_LIM);
                    if (fright_cnt == 13'd1) begin
                        mode_q <= phase_q[0] ? MODE_CHASE : MODE_SCATTER;
                    end
                end
            end else if (tick && (phase_q != 3'd7)) begin
                if (phase_cnt == (phase_dur - 21'd1)) begin
                    phase_q   <= phase_q + 3'd1;
                    phase_cnt <= '0;
                    mode_q    <= phase_q[0] ? MODE_SCATTER : MODE_CHASE;
                    reverse_q <= 1'b1;
                end else begin
                    phase_cnt <= phase_cnt + 21'd1;
                end
            end
        end
    end

    assign o_mode         = mode_q;
    assign o_phase        = phase_q;
    assign o_reverse      = reverse_q;
    assign o_fright_flash = flash_q;

endmodule
